mem_arbiter: RTL

- Shares one slow 128-bit line memory between the I-cache and D-cache miss/write-back ports.
- Sits between the two cache instances and the single external memory port, on the cache side of the memory-response register stage.
- Arbitrates, latches and forwards one line transaction at a time, then routes the one-cycle ready pulse back to the winning cache.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_pick.sv | 32 +++
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D-cache line memory arbiter.
// Optional build macro MEM_ARB_RR_EN (used by mem_arb_pick / mem_arbiter)
// selects round-robin arbitration instead of fixed D-over-I priority.
package mem_arb_pkg;

    localparam int ADDR_W_DEF   = 28;
    localparam int LINE_W_DEF   = 128;
    localparam int MAX_WAIT_DEF = 255;
    localparam int WAIT_W       = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_I    = 2'b01,
        OWN_D    = 2'b10
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the I-cache and D-cache requests.
// With MEM_ARB_RR_EN defined a tie is broken by rr_ptr (0 favours D,
// 1 favours I); otherwise D always beats I and rr_ptr does not exist.
module mem_arb_pick (
    input  logic i_req,
    input  logic d_req,
`ifdef MEM_ARB_RR_EN
    input  logic rr_ptr,
`endif
    output logic pick_i,
    output logic pick_d
);

    // Winner select: at most one of pick_i / pick_d is ever high.
    always_comb begin
        pick_i = 1'b0;
        pick_d = 1'b0;
`ifdef MEM_ARB_RR_EN
        if (i_req && d_req) begin
            pick_i = rr_ptr;
            pick_d = ~rr_ptr;
        end else begin
            pick_i = i_req;
            pick_d = d_req;
        end
`else
        pick_d = d_req;
        pick_i = i_req & ~d_req;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one slow line memory between the I-cache and D-cache ports.
// One transaction at a time: arbitrate in IDLE, latch the winner's request,
// drive memory from the latched copy, pass mem_ready back to the owner,
// then spend one DONE cycle idle so the served cache can drop its request.
// Optional build macro MEM_ARB_RR_EN enables round-robin arbitration.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int LINE_W   = LINE_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        arb_owner,
    output logic              arb_timeout
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_SAT   = '1;

    arb_state_t        state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
`ifdef MEM_ARB_RR_EN
    logic              rr_ptr_q, rr_ptr_d;
`endif

    logic i_req, d_req, pick_i, pick_d;
    logic granted, timeout_hit, complete;

    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;

    mem_arb_pick u_pick (
        .i_req  (i_req),
        .d_req  (d_req),
`ifdef MEM_ARB_RR_EN
        .rr_ptr (rr_ptr_q),
`endif
        .pick_i (pick_i),
        .pick_d (pick_d)
    );

    assign granted     = (state_q == GRANT_I) || (state_q == GRANT_D);
    // A real mem_ready in the last allowed cycle wins over the timeout.
    assign timeout_hit = granted && !mem_ready && (wait_q == MAX_WAIT_C);
    assign complete    = granted && (mem_ready || timeout_hit);

    // Next-state, request latching, wait counter and sticky timeout flag.
    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
`ifdef MEM_ARB_RR_EN
        rr_ptr_d  = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                // Write wins when a port raises both read and write.
                if (pick_d) begin
                    state_d = GRANT_D;
                    write_d = d_write;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    wait_d  = '0;
                end else if (pick_i) begin
                    state_d = GRANT_I;
                    write_d = i_write;
                    addr_d  = i_addr;
                    wdata_d = i_wdata;
                    wait_d  = '0;
                end
            end
            GRANT_I, GRANT_D: begin
                if (complete) begin
                    state_d = DONE;
                    if (timeout_hit) timeout_d = 1'b1;
                end else if (wait_q != WAIT_SAT) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef MEM_ARB_RR_EN
                rr_ptr_d = ~rr_ptr_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latch registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
            rr_ptr_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
`ifdef MEM_ARB_RR_EN
            rr_ptr_q  <= rr_ptr_d;
`endif
        end
    end

    // Memory-side and cache-side outputs decoded from the current state.
    always_comb begin
        mem_read    = granted & ~write_q;
        mem_write   = granted & write_q;
        mem_addr    = addr_q;
        mem_wdata   = wdata_q;
        i_ready     = (state_q == GRANT_I) && complete;
        d_ready     = (state_q == GRANT_D) && complete;
        i_rdata     = timeout_hit ? '0 : mem_rdata;
        d_rdata     = timeout_hit ? '0 : mem_rdata;
        arb_timeout = timeout_q;
        case (state_q)
            GRANT_I: arb_owner = OWN_I;
            GRANT_D: arb_owner = OWN_D;
            default: arb_owner = OWN_NONE;
        endcase
    end

endmodule
